rx_fifo: RTL
============

Name: rx_fifo

Overview:
- Receive-side byte buffer sitting directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle ready strobe and stores it in a circular FIFO.
- Presents bytes to the core-side consumer through a first-word-fall-through valid/ready interface.
- Flags bytes dropped on overflow with a sticky bit.

Parameters:
- DEPTH_LOG2, 4, log2 of FIFO depth; depth = 2**DEPTH_LOG2 entries (16 by default).
- WIDTH, 8, data width in bits; matches the receiver byte width.

Ports:
- clk  input  1  clock; same clock as the UART receiver (baud x4).
- res  input  1  synchronous, active-high reset.
- rx_byte  input  WIDTH  received byte from the receiver; valid while rx_rdy is high.
- rx_rdy  input  1  receiver byte-ready strobe.
- out_data  output  WIDTH  byte at the FIFO head; valid when out_valid is high.
- out_valid  output  1  FIFO not empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- overflow  output  1  sticky: at least one byte was dropped because the FIFO was full.
- clr_ovf  input  1  one-cycle pulse clears overflow.
- level  output  DEPTH_LOG2+1  occupancy count; present only with RX_FIFO_LEVEL_EN.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - Reset is synchronous and active-high on res; it takes priority over all other activity.
- Reset values:
  - Write pointer, read pointer and rdy_q are 0.
  - out_valid=0, overflow=0, level=0.
  - out_data=0; the storage array is not reset.
- Pointers:
  - wr_ptr and rd_ptr are DEPTH_LOG2+1 bits wide.
  - empty = (wr_ptr == rd_ptr).
  - full = MSBs differ and the lower bits are equal.
  - Pointers wrap naturally modulo 2**(DEPTH_LOG2+1).
- Push:
  - push = rx_rdy & ~rdy_q, where rdy_q is rx_rdy registered. This is a rising-edge detect, so a strobe held high for several cycles writes exactly one byte.
  - A push writes rx_byte to mem[wr_ptr low bits] and increments wr_ptr.
- Pop:
  - pop = out_valid & out_ready; it increments rd_ptr.
  - out_data is mem[rd_ptr low bits], read combinationally (first-word fall-through).
  - out_valid = ~empty.
- Latency: a byte pushed in cycle N makes out_valid high in cycle N+1 with that byte on out_data.
- Full plus push:
  - Without a pop in the same cycle, the byte is dropped, pointers are unchanged and overflow is set to 1 at the next edge.
  - With a pop in the same cycle, both occur; no drop, level unchanged.
- Empty plus push: no pop is possible (out_valid=0); the byte is written.
- out_ready while empty: ignored; no pointer movement.
- Overflow flag:
  - Holds until clr_ovf.
  - If clr_ovf and a new drop occur in the same cycle, the drop wins and overflow stays 1.
- Reset mid-stream: all contents are discarded and overflow is cleared. An rx_rdy high during reset is ignored: rdy_q resets to 0, and the first post-reset cycle with rx_rdy high counts as a new edge.
- No state machine beyond the pointers. Control is an occupancy-driven empty / partial / full classification derived from the pointers.

Optional Feature:
- Macro: RX_FIFO_LEVEL_EN.
- Defined:
  - Port level (DEPTH_LOG2+1 bits) is present and equals wr_ptr - rd_ptr, computed modulo 2**(DEPTH_LOG2+1).
  - level updates the cycle after each push or pop; it ranges 0..2**DEPTH_LOG2.
- Undefined: the port and its subtractor are absent; all other behaviour is identical.

Decomposition:
- Package rx_pkg:
  - Localparams RX_WIDTH=8 and RX_FIFO_DEPTH_LOG2=4, used as parameter defaults.
  - Shared pointer-width helper constant.
- Sub-module rx_fifo_mem:
  - Simple dual-port register array with a synchronous write port and an asynchronous read port, parameterised by WIDTH and DEPTH_LOG2.
  - rx_fifo holds the pointers, edge detect and flags.

Test Plan:
1. Single byte: after reset, pulse rx_rdy one cycle with rx_byte=8'hA5, out_ready=0 -> next cycle out_valid=1, out_data=8'hA5; assert out_ready one cycle -> out_valid=0.
2. Ordering and wrap: push 40 bytes 8'h00..8'h27 with out_ready=1 continuously -> consumer receives 8'h00..8'h27 in order with no loss; pointers wrap twice.
3. Overflow: push 17 bytes 8'h10..8'h20 with out_ready=0 -> overflow=1 after the 17th; draining yields 8'h10..8'h1F only; pulse clr_ovf -> overflow=0.
4. Full with simultaneous push and pop: fill 16 entries, then same-cycle rx_rdy edge (8'hEE) and out_ready=1 -> overflow stays 0, level stays 16 (with RX_FIFO_LEVEL_EN), 8'hEE emerges last.
5. Held strobe: hold rx_rdy high 5 cycles with rx_byte=8'h3C -> exactly one entry written (level=1).
6. Reset mid-stream: 6 bytes buffered and overflow=1, assert res one cycle -> out_valid=0, overflow=0, level=0; a subsequent push of 8'h55 appears as the sole entry.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared defaults and types for the UART receive FIFO.
package rx_pkg;

    localparam int unsigned RX_WIDTH           = 8;
    localparam int unsigned RX_FIFO_DEPTH_LOG2 = 4;

    // Pointers carry one extra wrap bit beyond the address bits.
    function automatic int unsigned ptr_width(input int unsigned depth_log2);
        return depth_log2 + 1;
    endfunction

    localparam int unsigned RX_PTR_W = ptr_width(RX_FIFO_DEPTH_LOG2);

    typedef enum logic [1:0] {
        OccEmpty,
        OccPartial,
        OccFull
    } occ_e;

endpackage

// File: rtl/rx_fifo_mem.sv
// Register array for the receive FIFO: synchronous write, asynchronous read.
module rx_fifo_mem
    import rx_pkg::*;
#(
    parameter int unsigned WIDTH      = RX_WIDTH,
    parameter int unsigned DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_fifo.sv
// Receive-side byte FIFO with first-word-fall-through output and sticky overflow.
// Optional occupancy port enabled by defining RX_FIFO_LEVEL_EN.
module rx_fifo
    import rx_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = RX_FIFO_DEPTH_LOG2,
    parameter int unsigned WIDTH      = RX_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] rx_byte,
    input  logic             rx_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overflow,
    input  logic             clr_ovf
`ifdef RX_FIFO_LEVEL_EN
    ,
    output logic [DEPTH_LOG2:0] level
`endif
);

    localparam int unsigned PTR_W = ptr_width(DEPTH_LOG2);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rdy_q, rdy_d;
    logic             ovf_q, ovf_d;

    logic             empty;
    logic             full;
    occ_e             occ;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             drop;
    logic [WIDTH-1:0] mem_rdata;

    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);

        if (empty) begin
            occ = OccEmpty;
        end else if (full) begin
            occ = OccFull;
        end else begin
            occ = OccPartial;
        end

        // Rising-edge detect so a held strobe writes a single byte.
        push  = rx_rdy & ~rdy_q;
        pop   = (occ != OccEmpty) & out_ready;
        // A pop frees the head slot in the same cycle, so full+push+pop still writes.
        wr_en = push & ((occ != OccFull) | pop);
        drop  = push & (occ == OccFull) & ~pop;

        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        rdy_d    = rx_rdy;

        // A new drop outranks a simultaneous clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            rdy_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rdy_q    <= rdy_d;
            ovf_q    <= ovf_d;
        end
    end

    rx_fifo_mem #(
        .WIDTH      (WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr_q[PTR_W-2:0]),
        .wdata (rx_byte),
        .raddr (rd_ptr_q[PTR_W-2:0]),
        .rdata (mem_rdata)
    );

    // Storage is not reset; gate the head so out_data reads zero while empty.
    assign out_valid = (occ != OccEmpty);
    assign out_data  = out_valid ? mem_rdata : '0;
    assign overflow  = ovf_q;

`ifdef RX_FIFO_LEVEL_EN
    assign level = wr_ptr_q - rd_ptr_q;
`endif

endmodule
